// File: rtl/db_pkg.sv
// Shared definitions for the switch debouncers: per-switch state encoding
// and a ceiling-log2 helper for sizing counters.
package db_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } db_st_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/db_tick_gen.sv
// Free-running prescaler: tick is high for one clk cycle every TICK_DIV cycles.
module db_tick_gen
    import db_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_sw_db_sched.sv
// Round-robin debounce scheduler: one shared evaluation engine services one
// switch slot per cycle, using per-slot state/count arrays and a shared tick.
module multi_sw_db_sched
    import db_pkg::*;
#(
    parameter int N        = 4,
    parameter int TICK_DIV = 100000,
    parameter int DB_TICKS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw,
    output logic [N-1:0] db,
    output logic [N-1:0] db_rise,
    output logic [N-1:0] db_fall
);

    localparam int CW = clog2(DB_TICKS + 1);
    localparam int PW = (N > 1) ? clog2(N) : 1;

    logic          tick;
    logic [N-1:0]  sync1_q, sync2_q;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  pend_q, pend_d;
    db_st_e        st_q  [N];
    logic [CW-1:0] cnt_q [N];
    logic [N-1:0]  db_q, db_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;

    db_st_e        slot_st, slot_st_d;
    logic [CW-1:0] slot_cnt, slot_cnt_d;
    logic          slot_s, slot_p;

    db_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign db      = db_q;
    assign db_rise = rise_q;
    assign db_fall = fall_q;

    // Pending ticks: a fresh tick re-arms every slot, overriding this cycle's clear.
    always_comb begin
        ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + 1'b1;
        pend_d = pend_q;
        pend_d[ptr_q] = 1'b0;
        if (tick) begin
            pend_d = '1;
        end
    end

    always_comb begin
        slot_st    = st_q[ptr_q];
        slot_cnt   = cnt_q[ptr_q];
        slot_s     = sync2_q[ptr_q];
        slot_p     = pend_q[ptr_q];
        slot_st_d  = slot_st;
        slot_cnt_d = slot_cnt;
        db_d       = db_q;
        rise_d     = '0;
        fall_d     = '0;
        unique case (slot_st)
            ST_IDLE_LO: begin
                if (slot_s) begin
                    slot_st_d  = ST_WAIT_HI;
                    slot_cnt_d = CW'(DB_TICKS);
                end
            end
            ST_WAIT_HI: begin
                if (!slot_s) begin
                    slot_st_d = ST_IDLE_LO;
                end else if (slot_p) begin
                    if (slot_cnt == CW'(1)) begin
                        slot_st_d     = ST_IDLE_HI;
                        db_d[ptr_q]   = 1'b1;
                        rise_d[ptr_q] = 1'b1;
                    end else begin
                        slot_cnt_d = slot_cnt - 1'b1;
                    end
                end
            end
            ST_IDLE_HI: begin
                if (!slot_s) begin
                    slot_st_d  = ST_WAIT_LO;
                    slot_cnt_d = CW'(DB_TICKS);
                end
            end
            ST_WAIT_LO: begin
                if (slot_s) begin
                    slot_st_d = ST_IDLE_HI;
                end else if (slot_p) begin
                    if (slot_cnt == CW'(1)) begin
                        slot_st_d     = ST_IDLE_LO;
                        db_d[ptr_q]   = 1'b0;
                        fall_d[ptr_q] = 1'b1;
                    end else begin
                        slot_cnt_d = slot_cnt - 1'b1;
                    end
                end
            end
            default: begin
                slot_st_d = ST_IDLE_LO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ptr_q   <= '0;
            pend_q  <= '0;
            db_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= ST_IDLE_LO;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sw;
            sync2_q      <= sync1_q;
            ptr_q        <= ptr_d;
            pend_q       <= pend_d;
            st_q[ptr_q]  <= slot_st_d;
            cnt_q[ptr_q] <= slot_cnt_d;
            db_q         <= db_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

endmodule

// File: tb/tb_multi_sw_db_sched.sv
// Bench for multi_sw_db_sched: directed scenarios plus random switch activity,
// judged against a history-based model of when a debounced change is allowed.
module tb_multi_sw_db_sched;

    localparam int N       = 4;
    localparam int TD      = 10;
    localparam int DBT     = 3;
    localparam int HMAX    = 20000;
    localparam int LAT_MIN = 22;
    localparam int LAT_MAX = 40;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sw    = '0;
    logic [N-1:0] db, db_rise, db_fall;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hist [HMAX][N];
    logic [N-1:0] prev_db = '0;
    int rise_cnt [N];
    int fall_cnt [N];
    int rise_cyc [N];
    int fall_cyc [N];
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    multi_sw_db_sched #(
        .N        (N),
        .TICK_DIV (TD),
        .DB_TICKS (DBT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .db      (db),
        .db_rise (db_rise),
        .db_fall (db_fall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic bit in_win(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    // True when switch i held level v at every sampled edge a..b (reset counts as no level).
    function automatic bit stable(input int i, input int a, input int b, input int v);
        if (a < 1 || b >= HMAX) return 1'b0;
        for (int k = a; k <= b; k++) begin
            if (hist[k][i] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < HMAX) begin
            for (int i = 0; i < N; i++) begin
                hist[cyc][i] = reset ? int'(sw[i]) : -1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset) begin
                chk("rst_db", {28'b0, db}, 32'd0);
                chk("rst_rise", {28'b0, db_rise}, 32'd0);
                chk("rst_fall", {28'b0, db_fall}, 32'd0);
                prev_db = '0;
            end else begin
                chk("rise_match", {28'b0, db_rise}, {28'b0, db & ~prev_db});
                chk("fall_match", {28'b0, db_fall}, {28'b0, ~db & prev_db});
                chk("one_change", {31'b0, ($countones(db ^ prev_db) <= 1)}, 32'd1);
                for (int i = 0; i < N; i++) begin
                    if (db[i] != prev_db[i]) begin
                        chk("change_supported", {31'b0, stable(i, cyc - 18, cyc - 2, int'(db[i]))}, 32'd1);
                        if (db[i]) begin
                            rise_cnt[i]++;
                            rise_cyc[i] = cyc;
                        end else begin
                            fall_cnt[i]++;
                            fall_cyc[i] = cyc;
                        end
                    end
                    if (cyc > 42 && cyc < HMAX && hist[cyc][i] >= 0 &&
                        stable(i, cyc - 42, cyc, hist[cyc][i])) begin
                        chk("settled", {31'b0, db[i]}, hist[cyc][i]);
                    end
                end
                prev_db = db;
            end
        end
    end

    initial begin
        int t0;
        int snap [N];
        int tot;
        bit distinct;

        for (int i = 0; i < N; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
            rise_cyc[i] = 0;
            fall_cyc[i] = 0;
        end

        // Reset held for 3 cycles, then 200 idle cycles.
        #1 reset = 1'b0;
        mon_en = 1'b1;
        step(3);
        chk("reset_db", {28'b0, db}, 32'd0);
        reset = 1'b1;
        step(200);
        chk("idle_db", {28'b0, db}, 32'd0);
        tot = 0;
        for (int i = 0; i < N; i++) tot += rise_cnt[i] + fall_cnt[i];
        chk("idle_pulses", tot, 32'd0);

        // Clean press on switch 1.
        t0 = cyc;
        sw[1] = 1'b1;
        step(45);
        chk("press_db", {28'b0, db}, 32'b0010);
        chk("press_rise_cnt", rise_cnt[1], 32'd1);
        chk("press_latency", {31'b0, in_win(rise_cyc[1] - t0)}, 32'd1);
        chk("press_others", rise_cnt[0] + rise_cnt[2] + rise_cnt[3] + fall_cnt[1], 32'd0);

        // Bouncing switch 2, then a solid hold.
        snap[2] = rise_cnt[2];
        for (int k = 0; k < 10; k++) begin
            sw[2] = ~sw[2];
            step(7);
            chk("bounce_hold", {31'b0, db[2]}, 32'd0);
        end
        sw[2] = 1'b1;
        t0 = cyc;
        step(45);
        chk("bounce_db", {31'b0, db[2]}, 32'd1);
        chk("bounce_rise_cnt", rise_cnt[2] - snap[2], 32'd1);
        chk("bounce_latency", {31'b0, in_win(rise_cyc[2] - t0)}, 32'd1);

        // Release glitch on switch 0, then a real release.
        sw[0] = 1'b1;
        step(45);
        chk("glitch_setup", {31'b0, db[0]}, 32'd1);
        snap[0] = fall_cnt[0];
        sw[0] = 1'b0;
        step(5);
        sw[0] = 1'b1;
        step(45);
        chk("glitch_no_fall", fall_cnt[0] - snap[0], 32'd0);
        chk("glitch_db", {31'b0, db[0]}, 32'd1);
        sw[0] = 1'b0;
        t0 = cyc;
        step(45);
        chk("release_fall_cnt", fall_cnt[0] - snap[0], 32'd1);
        chk("release_latency", {31'b0, in_win(fall_cyc[0] - t0)}, 32'd1);
        chk("release_db", {31'b0, db[0]}, 32'd0);

        // Simultaneous press on all switches.
        sw = '0;
        step(45);
        chk("sim_setup", {28'b0, db}, 32'd0);
        for (int i = 0; i < N; i++) snap[i] = rise_cnt[i];
        sw = '1;
        t0 = cyc;
        step(45);
        chk("sim_db", {28'b0, db}, 32'hF);
        for (int i = 0; i < N; i++) begin
            chk("sim_rise_cnt", rise_cnt[i] - snap[i], 32'd1);
            chk("sim_latency", {31'b0, in_win(rise_cyc[i] - t0)}, 32'd1);
        end
        distinct = 1'b1;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (rise_cyc[i] == rise_cyc[j]) distinct = 1'b0;
            end
        end
        chk("sim_distinct", {31'b0, distinct}, 32'd1);

        // Reset during a pending press of switch 3.
        sw = 4'b0111;
        step(45);
        chk("midrst_setup", {28'b0, db}, 32'b0111);
        sw[3] = 1'b1;
        step(10);
        chk("midrst_waiting", {31'b0, db[3]}, 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_db", {28'b0, db}, 32'd0);
        chk("midrst_rise", {28'b0, db_rise}, 32'd0);
        chk("midrst_fall", {28'b0, db_fall}, 32'd0);
        step(3);
        snap[3] = rise_cnt[3];
        reset = 1'b1;
        t0 = cyc;
        step(20);
        chk("midrst_early", {31'b0, db[3]}, 32'd0);
        step(25);
        chk("midrst_db_after", {28'b0, db}, 32'hF);
        chk("midrst_rise_cnt", rise_cnt[3] - snap[3], 32'd1);
        chk("midrst_latency", {31'b0, in_win(rise_cyc[3] - t0)}, 32'd1);

        // Random activity; the monitor judges every cycle.
        for (int k = 0; k < 40; k++) begin
            sw = N'($urandom);
            step(int'($urandom_range(5, 60)));
        end
        step(50);
        chk("final_db", {28'b0, db}, {28'b0, sw});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
